prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that sits directly upstream of the five-stage pipeline core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into the instruction memory's write port. It holds the core in reset through its `core_rst` output until the image is fully and correctly loaded, then releases it.

## Interface
Parameters:
- `DEPTH`, default 64: instruction memory size in 32-bit words.
- `ADDR_W`, default 6: word-address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- `clk`  input  1: the single clock; all state updates on its rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `in_valid`  input  1: `in_data` holds a byte.
- `in_data`  input  8: stream byte.
- `in_ready`  output  1: loader can accept a byte this cycle.
- `imem_we`  output  1: one-cycle instruction-memory write strobe.
- `imem_addr`  output  ADDR_W: word address of the write.
- `imem_wdata`  output  32: instruction word to write.
- `core_rst`  output  1: active-high reset to the pipeline core.
- `done`  output  1: image loaded, core running.
- `err`  output  1: sticky load error.

## Operation
- **Transfer rule:** a byte transfers on a rising edge where `in_valid && in_ready`. `in_data` is ignored otherwise.
- **Stream format:** 2-byte little-endian word count N, then N×4 payload bytes, each word little-endian (first byte → bits [7:0]).
- **States:**
  - `LEN0`: low count byte → `LEN1`.
  - `LEN1`: high count byte → `DATA` if N>0. If N=0 → `CSUM` when the macro is defined, else `RUN`.
  - `DATA`: a 2-bit byte counter fills a 32-bit shift register. On the 4th byte, register the word for write and increment the 16-bit word index. After word N-1 → `CSUM`/`RUN`.
  - `CSUM` (macro only): see Configuration.
  - `RUN`: terminal, `done`=1.
  - `ERR`: terminal, `core_rst` held at 1.
- **Writes:** `imem_we` pulses only for word index < DEPTH. `imem_addr` = index[ADDR_W-1:0].
- **Overflow:** words with index >= DEPTH are still consumed but not written. `err` sets at the first such word, and the end state becomes `ERR` instead of `RUN`.
- **`in_ready` by state:** 1 in `LEN0`, `LEN1`, `DATA` and `CSUM`; 0 in `RUN` and `ERR`. No further input is accepted until `rst`.
- **`core_rst`:** 1 in every state except `RUN`.

## Timing
- **Reset values:**
  - `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `core_rst`=1, `done`=0, `err`=0, state `LEN0`, counters 0.
- `in_ready` is registered. It rises at the first rising edge after `rst` deasserts and falls at the edge that enters `RUN` or `ERR`.
- **Write latency:** 4th byte of a word accepted at edge k → `imem_we`=1 with address and data valid from edge k to edge k+1, then 0.
- **Back-to-back bytes:** with `in_valid` held high, one byte transfers per cycle with no bubbles. Minimum spacing between successive `imem_we` pulses is 4 cycles.
- **Release:** last payload byte (or the N=0 high-count byte) accepted at edge k → state `RUN` at edge k. `core_rst`=0 and `done`=1 from edge k+1. The last word is therefore written strictly before the core leaves reset.
- **Stalls:** `in_valid` low at any point only stalls progress. Partial word and count are retained indefinitely.
- **Reset mid-load:** `rst` at any time returns everything to reset values immediately. Words already written stay in memory and are overwritten by the next load.

## Configuration
- **Macro `PROG_LOADER_CHECKSUM_EN`:**
  - **Defined:**
    - The stream carries one trailing checksum byte: XOR of all bytes after the count, including discarded overflow bytes.
    - `CSUM` accepts it. Match and no overflow → `RUN`, with release timing as above measured from the checksum edge.
    - Mismatch → `ERR` with `err`=1 from the next edge.
    - For N=0 the expected checksum is 0x00.
  - **Undefined:** no `CSUM` state and no trailer byte. A running XOR is not built.

## Test plan
- N=2, words 0x00500093, 0x00A00113, continuous valid → `imem_we` at addr 0 then addr 4 cycles later with those data. `core_rst` falls one cycle after the last byte, `done`=1, `in_ready`=0.
- Same stream with `in_valid` toggled every other cycle → identical writes, each `imem_we` one cycle after its 4th accepted byte, no spurious strobes.
- N=0 (bytes 00 00, plus 00 with macro) → no `imem_we`, `core_rst`=0 one cycle after the last byte, `err`=0.
- DEPTH=4, N=5 → 4 writes (addr 0-3), 5th word consumed but not written, `err`=1 at its 4th byte, final state `ERR`, `core_rst` stays 1.
- Macro defined, N=1 word 0x12345678, checksum 0x08 → `RUN`. Same stream with checksum 0x09 → `ERR`, `err`=1, `core_rst`=1.
- Assert `rst` after 6 payload bytes, then send a fresh N=1 stream → loader restarts at `LEN0`, single write at addr 0, clean release.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: byte stream -> little-endian 32-bit words -> imem write port,
// holding the core in reset until the image is loaded. Optional trailer check: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] shreg_q;
  logic        we_d;
  logic        err_d;
  logic        xfer;
  logic        in_range;
  logic        last_word;
  logic        ovf_end;
  logic [31:0] word_full;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign xfer      = in_valid && in_ready;
  assign word_full = {in_data, shreg_q};
  assign in_range  = 32'(idx_q) < 32'(DEPTH);
  assign last_word = idx_q == (cnt_q - 16'd1);
  assign ovf_end   = err_q_or_ovf(err, in_range);

  function automatic logic err_q_or_ovf(input logic err_now, input logic fits);
    return err_now || !fits;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    we_d    = 1'b0;
    err_d   = err || (state_q == ERR);
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      LEN0: begin
        if (xfer) begin
          cnt_d[7:0] = in_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (xfer) begin
          cnt_d[15:8] = in_data;
          if ({in_data, cnt_q[7:0]} == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = RUN;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          bcnt_d = bcnt_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (bcnt_q == 2'd3) begin
            idx_d = idx_q + 16'd1;
            // Out-of-range words are still consumed so the stream stays aligned.
            if (in_range) we_d = 1'b1;
            else          err_d = 1'b1;
            if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = ovf_end ? ERR : RUN;
`endif
            end
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) state_d = (in_data == csum_q && !err) ? RUN : ERR;
      end
`endif
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LEN0;
      cnt_q      <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      in_ready <= !(state_d == RUN || state_d == ERR);
      imem_we  <= we_d;
      if (we_d) begin
        imem_addr  <= idx_q[ADDR_W-1:0];
        imem_wdata <= word_full;
      end
      // Release lags the RUN transition by one edge so the last write lands first.
      core_rst <= state_q != RUN;
      done     <= state_q == RUN;
      err      <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Partial-word bytes need no reset: the byte counter decides which are live.
  always_ff @(posedge clk) begin
    if (state_q == DATA && xfer) shreg_q <= {in_data, shreg_q[23:8]};
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (DEPTH=4 so overflow is reachable); follows PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, imem_we, core_rst, done, err;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]  stim[$];
  int          xe[64];
  int          nx;
  logic [31:0] wa[16];
  logic [31:0] wd[16];
  int          wc[16];
  int          nw;

  prog_loader #(.DEPTH(4), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log transfers (edge at which they happen) and write strobes (edge that raised them).
  always @(negedge clk) begin
    if (rst) begin
      nx = 0;
      nw = 0;
    end else begin
      if (in_valid && in_ready && nx < 64) begin
        xe[nx] = cyc + 1;
        nx++;
      end
      if (imem_we && nw < 16) begin
        wa[nw] = 32'(imem_addr);
        wd[nw] = imem_wdata;
        wc[nw] = cyc;
        nw++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    check("ready_wait", {31'd0, in_ready}, 32'd1);
    tick();
  endtask

  task automatic send_range(input int from, input int to, input int gap);
    for (int i = from; i < to; i++) send_byte(stim[i], gap);
    in_valid = 1'b0;
  endtask

  task automatic check_release(input string tag);
    check({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_rst_held"},  {31'd0, core_rst}, 32'd1);
    tick();
    check({tag, "_core_rst"},  {31'd0, core_rst}, 32'd0);
    check({tag, "_done"},      {31'd0, done},     32'd1);
    check({tag, "_err"},       {31'd0, err},      32'd0);
  endtask

  task automatic check_two_words(input string tag);
    check({tag, "_nw"},    32'(nw), 32'd2);
    check({tag, "_a0"},    wa[0], 32'd0);
    check({tag, "_d0"},    wd[0], 32'h00500093);
    check({tag, "_a1"},    wa[1], 32'd1);
    check({tag, "_d1"},    wd[1], 32'h00A00113);
    check({tag, "_lat0"},  32'(wc[0]), 32'(xe[5]));
    check({tag, "_lat1"},  32'(wc[1]), 32'(xe[9]));
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we",       {31'd0, imem_we},  32'd0);
    check("rst_addr",     32'(imem_addr),    32'd0);
    check("rst_wdata",    imem_wdata,        32'd0);
    check("rst_core_rst", {31'd0, core_rst}, 32'd1);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // N=2, continuous valid
    stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
    stim.push_back(8'h71);
`endif
    send_range(0, stim.size(), 0);
    check_release("t1");
    check_two_words("t1");
    check("t1_spacing", 32'(wc[1] - wc[0]), 32'd4);

    // Same stream, valid toggled
    do_reset();
    send_range(0, stim.size(), 1);
    check_release("t2");
    check_two_words("t2");

    // N=0
    do_reset();
    stim = '{8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    send_range(0, stim.size(), 0);
    check_release("t3");
    check("t3_nw", 32'(nw), 32'd0);

    // Overflow: N=5 into DEPTH=4 (each word's bytes XOR to zero)
    do_reset();
    stim = '{8'h05, 8'h00};
    for (int w = 0; w < 5; w++)
      for (int b = 0; b < 4; b++) stim.push_back(8'(w + 1));
`ifdef PROG_LOADER_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    send_range(0, 18, 0);
    check("t4_err_before", {31'd0, err}, 32'd0);
    send_range(18, 22, 0);
    check("t4_err_at_ovf", {31'd0, err}, 32'd1);
    send_range(22, stim.size(), 0);
    repeat (3) tick();
    check("t4_nw", 32'(nw), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t4_addr", wa[i], 32'(i));
      check("t4_data", wd[i], {4{8'(i + 1)}});
    end
    check("t4_core_rst", {31'd0, core_rst}, 32'd1);
    check("t4_done",     {31'd0, done},     32'd0);
    check("t4_ready",    {31'd0, in_ready}, 32'd0);
    check("t4_err_hold", {31'd0, err},      32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum good and bad
    do_reset();
    stim = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_range(0, stim.size(), 0);
    check_release("t5");
    check("t5_data", wd[0], 32'h12345678);
    do_reset();
    stim[6] = 8'h09;
    send_range(0, stim.size(), 0);
    check("t5b_ready", {31'd0, in_ready}, 32'd0);
    check("t5b_err_early", {31'd0, err}, 32'd0);
    tick();
    check("t5b_err",      {31'd0, err},      32'd1);
    check("t5b_core_rst", {31'd0, core_rst}, 32'd1);
    check("t5b_done",     {31'd0, done},     32'd0);
`endif

    // Reset mid-load, then a fresh N=1 load
    do_reset();
    stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_range(0, stim.size(), 0);
    check("t6_first_write", wd[0], 32'h44332211);
    rst = 1'b1;
    #1;
    check("t6_async_ready",    {31'd0, in_ready}, 32'd0);
    check("t6_async_core_rst", {31'd0, core_rst}, 32'd1);
    check("t6_async_wdata",    imem_wdata,        32'd0);
    do_reset();
    stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef PROG_LOADER_CHECKSUM_EN
    stim.push_back(8'h22);
`endif
    send_range(0, stim.size(), 0);
    check_release("t6");
    check("t6_nw",   32'(nw), 32'd1);
    check("t6_addr", wa[0],   32'd0);
    check("t6_data", wd[0],   32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
